// File: rtl/pwm_demodulator.sv
// PWM demodulator: measures the period (rise to rise) and the high time of an
// asynchronous PWM input in clk_i cycles. The first rise after reset or after a
// timeout only arms the measurement. If no rise arrives within TIMEOUT cycles,
// the block drops back to IDLE and raises timeout_o until the next valid result.
module pwm_demodulator #(
    parameter int unsigned     BW      = 24,
    parameter logic [BW-1:0]   TIMEOUT = 24'd2400000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          pwm_i,
    output logic [BW-1:0] period_o,
    output logic [BW-1:0] high_o,
    output logic          valid_o,
    output logic          timeout_o
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    state_t        r_state;
    logic          r_s1;
    logic          r_s2;
    logic          r_s3;
    logic [BW-1:0] r_cnt;
    logic [BW-1:0] r_hcnt;
    logic [BW-1:0] r_period;
    logic [BW-1:0] r_high;
    logic          r_valid;
    logic          r_timeout;

    logic          w_rise;
    logic          w_at_limit;

    // s2 is the synchronized level; s3 holds it for one more cycle for edge detection.
    assign w_rise     = r_s2 & ~r_s3;
    assign w_at_limit = (r_cnt == TIMEOUT);

    // Three-flop chain bringing the asynchronous input into the clk_i domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= pwm_i;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Measurement FSM with counters and registered outputs. A rise takes
    // priority over the timeout, so a period of exactly TIMEOUT still measures.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hcnt    <= '0;
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // The first edge only arms; timeout_o stays as it was.
                    if (w_rise) begin
                        r_state <= ST_MEASURE;
                        r_cnt   <= BW'(1);
                        r_hcnt  <= BW'(1);
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        r_period  <= r_cnt;
                        r_high    <= r_hcnt;
                        r_valid   <= 1'b1;
                        r_timeout <= 1'b0;
                        r_cnt     <= BW'(1);
                        r_hcnt    <= BW'(1);
                    end else if (w_at_limit) begin
                        // Counters stop here, so they can never wrap.
                        r_state   <= ST_IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + BW'(1);
                        if (r_s2) begin
                            r_hcnt <= r_hcnt + BW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign period_o  = r_period;
    assign high_o    = r_high;
    assign valid_o   = r_valid;
    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_pwm_demodulator.sv
// Testbench for pwm_demodulator. The whole input waveform (pwm level and reset
// per clock edge) is planned first. Expected outputs are then derived from
// rise-edge times: a result appears two edges after the synchronized rise,
// the period is the distance between rises, the high time is the number of
// high samples in between, and a timeout fires TIMEOUT edges after a rise
// with no successor. Finally the waveform is played and compared every cycle.
module tb_pwm_demodulator;

    localparam int BW   = 24;
    localparam int TO   = 1000;
    localparam int MAXN = 32768;

    logic          clk_i;
    logic          rst_i;
    logic          pwm_i;
    logic [BW-1:0] period_o;
    logic [BW-1:0] high_o;
    logic          valid_o;
    logic          timeout_o;

    pwm_demodulator #(
        .BW      (BW),
        .TIMEOUT (24'd1000)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .pwm_i     (pwm_i),
        .period_o  (period_o),
        .high_o    (high_o),
        .valid_o   (valid_o),
        .timeout_o (timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Planned stimulus, one entry per rising clock edge.
    logic wave_lvl [MAXN];
    logic wave_rst [MAXN];
    int   nwave;

    // Expected outputs visible just after each edge.
    logic exp_valid   [MAXN];
    logic exp_timeout [MAXN];
    int   exp_period  [MAXN];
    int   exp_high    [MAXN];

    int checks;
    int errors;

    task automatic add(input logic lvl, input int n, input logic r);
        for (int i = 0; i < n; i++) begin
            if (nwave < MAXN) begin
                wave_lvl[nwave] = lvl;
                wave_rst[nwave] = r;
                nwave++;
            end
        end
    endtask

    task automatic pulse(input int p, input int h);
        add(1'b1, h, 1'b0);
        add(1'b0, p - h, 1'b0);
    endtask

    initial begin
        int   smp      [MAXN];
        int   ones_pre [MAXN+1];
        int   last_rise;
        logic m_to;
        int   m_per;
        int   m_hi;
        int   p;
        int   h;
        logic [2*BW+1:0] obs;
        logic [2*BW+1:0] expv;

        checks = 0;
        errors = 0;
        nwave  = 0;
        rst_i  = 1'b1;
        pwm_i  = 1'b0;

        // ---- plan the waveform ----
        add(1'b0, 4, 1'b1);                                  // power-on reset
        add(1'b0, 16, 1'b0);
        for (int i = 0; i < 7; i++) pulse(125, 40);          // steady 125/40
        for (int i = 0; i < 3; i++) pulse(200, 1);           // minimum high
        for (int i = 0; i < 3; i++) pulse(200, 199);         // maximum high
        for (int i = 0; i < 3; i++) pulse(TO, $urandom_range(1, TO - 1)); // period at limit
        pulse(TO + 1, $urandom_range(1, TO));                // one cycle too long
        for (int i = 0; i < 3; i++) pulse(TO, $urandom_range(1, TO - 1));
        add(1'b1, 30, 1'b0);                                 // single rise, then low
        add(1'b0, TO + 300, 1'b0);
        add(1'b1, TO + 300, 1'b0);                           // constant high
        add(1'b0, 20, 1'b0);
        for (int i = 0; i < 3; i++) pulse(125, 40);
        add(1'b1, 40, 1'b0);                                 // reset 50 cycles into a period
        add(1'b0, 10, 1'b0);
        add(1'b0, 3, 1'b1);
        add(1'b0, 72, 1'b0);
        for (int i = 0; i < 4; i++) pulse(125, 40);
        for (int i = 0; i < 12; i++) begin                   // random periods around the limit
            p = $urandom_range(2, TO + 100);
            h = $urandom_range(1, p - 1);
            pulse(p, h);
        end
        pulse(2, 1);
        pulse(2, 1);
        pulse(3, 2);
        add(1'b0, 10, 1'b0);

        // ---- reference model ----
        ones_pre[0] = 0;
        for (int n = 0; n < nwave; n++) begin
            smp[n]          = (wave_rst[n] || !wave_lvl[n]) ? 0 : 1;
            ones_pre[n + 1] = ones_pre[n] + smp[n];
        end
        last_rise = -1;
        m_to  = 1'b0;
        m_per = 0;
        m_hi  = 0;
        for (int e = 0; e < nwave; e++) begin
            exp_valid[e] = 1'b0;
            if (wave_rst[e]) begin
                last_rise = -1;
                m_to  = 1'b0;
                m_per = 0;
                m_hi  = 0;
            end else if (e >= 3 && smp[e - 2] == 1 && smp[e - 3] == 0) begin
                if (last_rise >= 0) begin
                    exp_valid[e] = 1'b1;
                    m_per = e - last_rise;
                    m_hi  = ones_pre[e - 2] - ones_pre[last_rise - 2];
                    m_to  = 1'b0;
                end
                last_rise = e;
            end else if (last_rise >= 0 && e - last_rise == TO) begin
                m_to = 1'b1;
                last_rise = -1;
            end
            exp_timeout[e] = m_to;
            exp_period[e]  = m_per;
            exp_high[e]    = m_hi;
        end

        // ---- play and compare ----
        for (int n = 0; n < nwave; n++) begin
            @(negedge clk_i);
            pwm_i = wave_lvl[n];
            rst_i = wave_rst[n];
            if (wave_rst[n]) begin
                #1;
                obs  = {valid_o, timeout_o, period_o, high_o};
                expv = '0;
                checks++;
                assert (obs === expv) else begin
                    errors++;
                    $error("FAIL async_reset cycle %0d: got valid=%b timeout=%b period=%0d high=%0d, want all zero",
                           n, valid_o, timeout_o, period_o, high_o);
                end
            end
            @(posedge clk_i);
            #1;
            obs  = {valid_o, timeout_o, period_o, high_o};
            expv = {exp_valid[n], exp_timeout[n], BW'(exp_period[n]), BW'(exp_high[n])};
            checks++;
            assert (obs === expv) else begin
                errors++;
                $error("FAIL outputs cycle %0d: got valid=%b timeout=%b period=%0d high=%0d, want valid=%b timeout=%b period=%0d high=%0d",
                       n, valid_o, timeout_o, period_o, high_o,
                       exp_valid[n], exp_timeout[n], exp_period[n], exp_high[n]);
            end
            if (exp_valid[n]) begin
                $display("measurement cycle %0d: period=%0d high=%0d", n, period_o, high_o);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
